sound_player: RTL and testbench

//  Reader/sequencer for the 16-bit sound ROM (6-bit addr, 1-cycle registered-address latency).
//  On a start pulse, fetches one clip of ROM words in address order and drives a square-wave buzzer.

---
 rtl/sound_player.sv | 224 ++++++++++++++++++++++
 tb/tb_sound_player.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_player.sv
// sound_player: sequencer for the 16-bit sound ROM (6-bit address, data valid one
// cycle after the address register is clocked). A start pulse selects one of four
// clips; its words are fetched in address order and rendered as a square wave.
//   Word format: [15:8] tone half-period in TONE_SCALE units (0 = rest),
//                [7:0]  duration in TICK_DIV-clock ticks (0 = skip word).
//   A word of 16'h0000 terminates the clip early.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, clip_sel   play request (ignored while busy) and clip index
//   stop              abort the current clip (no done pulse)
//   loop              (SOUND_PLAYER_LOOP_EN only) repeat the clip at its end
//   rom_addr/rom_data sound ROM interface
//   buzzer            square-wave audio output
//   busy, done        activity flag, one-cycle end-of-clip pulse
// Configuration: define SOUND_PLAYER_LOOP_EN to add the loop input.
module sound_player #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned TONE_SCALE = 64,
    parameter int unsigned CLIP_LEN   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  clip_sel,
    input  logic        stop,
`ifdef SOUND_PLAYER_LOOP_EN
    input  logic        loop,
`endif
    output logic [5:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        buzzer,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW  = 6;
    localparam int unsigned TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TCW = $clog2(255 * TONE_SCALE + 1);
    localparam int unsigned IW  = $clog2(CLIP_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_PLAY  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]      tone_q, tone_d;
    logic [7:0]      dur_q, dur_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic            buzzer_q, buzzer_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            loop_c;
    logic [TCW-1:0]  half_c;
    logic [IW-1:0]   idx_inc_c;
    logic            last_word_c;
    logic            go_next_c;
    logic            go_fin_c;

`ifdef SOUND_PLAYER_LOOP_EN
    assign loop_c = loop;
`else
    assign loop_c = 1'b0;
`endif

    // Half-period length in clocks; full-width product so tone 255 never truncates.
    always_comb begin
        half_c      = TCW'(tone_q) * TCW'(TONE_SCALE);
        idx_inc_c   = idx_q + IW'(1);
        last_word_c = (idx_inc_c == IW'(CLIP_LEN));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        tone_d     = tone_q;
        dur_d      = dur_q;
        tick_d     = tick_q;
        tcnt_d     = tcnt_q;
        buzzer_d   = buzzer_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        go_next_c  = 1'b0;
        go_fin_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = AW'(32'(clip_sel) * CLIP_LEN);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Address wraps modulo the 64-word ROM.
                rom_addr_d = base_q + AW'(idx_q);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                tone_d = rom_data[15:8];
                dur_d  = rom_data[7:0];
                if (rom_data == 16'h0000) begin
                    go_fin_c = 1'b1;
                end else if (rom_data[7:0] == 8'd0) begin
                    go_next_c = 1'b1;
                end else begin
                    tick_d   = '0;
                    tcnt_d   = '0;
                    buzzer_d = 1'b0;
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_d = '0;
                    dur_d  = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        go_next_c = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
                if (tone_q != 8'd0) begin
                    if (tcnt_q == half_c - TCW'(1)) begin
                        tcnt_d   = '0;
                        buzzer_d = ~buzzer_q;
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end else begin
                    buzzer_d = 1'b0;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Advance to the next word, or finish after the last one.
        if (go_next_c) begin
            buzzer_d = 1'b0;
            idx_d    = idx_inc_c;
            if (last_word_c) begin
                go_fin_c = 1'b1;
            end else begin
                state_d = S_FETCH;
            end
        end

        // End of clip: restart from word 0 when looping, else pulse done.
        if (go_fin_c) begin
            if (loop_c) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = S_FIN;
            end
        end

        // Abort wins over everything else outside IDLE.
        if (stop && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            buzzer_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            tone_q     <= '0;
            dur_q      <= '0;
            tick_q     <= '0;
            tcnt_q     <= '0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            rom_addr_q <= rom_addr_d;
            tone_q     <= tone_d;
            dur_q      <= dur_d;
            tick_q     <= tick_d;
            tcnt_q     <= tcnt_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign buzzer   = buzzer_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sound_player.sv
// Testbench for sound_player with TICK_DIV=10, TONE_SCALE=2 and a 64-word ROM
// model that registers the address. A per-word timeline model predicts buzzer,
// busy, done and rom_addr for every cycle of a clip.
module tb_sound_player;

    localparam int unsigned TICK_DIV   = 10;
    localparam int unsigned TONE_SCALE = 2;
    localparam int unsigned CLIP_LEN   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  clip_sel = 2'd0;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data;
    logic        buzzer;
    logic        busy;
    logic        done;
`ifdef SOUND_PLAYER_LOOP_EN
    logic        loop = 1'b0;
`endif

    logic [15:0] rom [64];

    sound_player #(
        .TICK_DIV   (TICK_DIV),
        .TONE_SCALE (TONE_SCALE),
        .CLIP_LEN   (CLIP_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clip_sel (clip_sel),
        .stop     (stop),
`ifdef SOUND_PLAYER_LOOP_EN
        .loop     (loop),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .buzzer   (buzzer),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic       buz;
        logic       bsy;
        logic       dn;
        logic [5:0] addr;
    } smp_t;

    typedef struct {
        logic [1:0]  cs;
        logic [15:0] w0;
        logic [15:0] w1;
        int          lat;
        int          tog;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    smp_t exp_q[$];
    logic [5:0] model_addr;
    int   model_fin_idx;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic check_smp(input int j, input smp_t e);
        smp_t g;
        g = {buzzer, busy, done, rom_addr};
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL sample %0d: got buz=%b busy=%b done=%b addr=%h expected buz=%b busy=%b done=%b addr=%h",
                     j, g.buz, g.bsy, g.dn, g.addr, e.buz, e.bsy, e.dn, e.addr);
        end
    endtask

    function automatic void push(input logic b, input logic by, input logic d, input logic [5:0] a);
        smp_t e;
        e.buz  = b;
        e.bsy  = by;
        e.dn   = d;
        e.addr = a;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle outputs for a whole clip, from the word list in the ROM.
    function automatic void build_model(input logic [1:0] cs);
        int base;
        int tone;
        int p;
        int half;
        logic [5:0] a;
        logic [15:0] w;
        exp_q.delete();
        base = int'(cs) * int'(CLIP_LEN);
        for (int i = 0; i < int'(CLIP_LEN); i++) begin
            a = 6'((base + i) % 64);
            w = rom[a];
            push(1'b0, 1'b1, 1'b0, model_addr);
            model_addr = a;
            push(1'b0, 1'b1, 1'b0, a);
            push(1'b0, 1'b1, 1'b0, a);
            if (w == 16'h0000) break;
            tone = int'(w[15:8]);
            p    = int'(w[7:0]) * int'(TICK_DIV);
            half = tone * int'(TONE_SCALE);
            for (int k = 0; k < p; k++) begin
                push((tone == 0) ? 1'b0 : 1'((k / half) % 2), 1'b1, 1'b0, a);
            end
        end
        model_fin_idx = exp_q.size();
        push(1'b0, 1'b1, 1'b1, model_addr);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, model_addr);
    endfunction

    // Call right after a negedge. poke >= 0 pulses start (clip 3) after that sample;
    // poke == -2 pulses it during the FIN cycle.
    task automatic run_clip(input logic [1:0] cs, input int poke,
                            output int lat, output int tog, output int ndone);
        smp_t e;
        logic prev_b;
        int   j;
        int   pk;
        build_model(cs);
        pk = (poke == -2) ? model_fin_idx : poke;
        start    = 1'b1;
        clip_sel = cs;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; tog = 0; ndone = 0; prev_b = 1'b0; j = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check_smp(j, e);
            if (done) begin
                ndone++;
                if (lat < 0) lat = j;
            end
            if (buzzer != prev_b) tog++;
            prev_b = buzzer;
            if (j == pk) begin
                start    = 1'b1;
                clip_sel = 2'd3;
            end else if (j == pk + 1) begin
                start = 1'b0;
            end
            j++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int lat, tog, nd;
        logic [15:0] w;
        logic [5:0] nxt;
        int got_next, seen_done;

        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        vecs[0] = '{2'd1, 16'h0302, 16'h0000, 26, 4};
        vecs[1] = '{2'd0, 16'h0005, 16'h0000, 56, 0};
        vecs[2] = '{2'd2, 16'h0000, 16'h0302, 3,  0};
        vecs[3] = '{2'd3, 16'h0100, 16'h0101, 19, 4};
        vecs[4] = '{2'd0, 16'h0A03, 16'h0000, 36, 2};
        vecs[5] = '{2'd1, 16'hFF01, 16'h0000, 16, 0};

        // Reset values.
        #1;
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset buzzer", int'(buzzer), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_addr = 6'h00;

        // Asynchronous reset while a tone is sounding.
        rom[16] = 16'h0302;
        @(negedge clk);
        start = 1'b1; clip_sel = 2'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset buzzer", int'(buzzer), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst buzzer", int'(buzzer), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst done", int'(done), 0);
        check("async rst rom_addr", int'(rom_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset busy", int'(busy), 0);
        model_addr = 6'h00;

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
            rom[int'(vecs[v].cs) * 16]     = vecs[v].w0;
            rom[int'(vecs[v].cs) * 16 + 1] = vecs[v].w1;
            run_clip(vecs[v].cs, -1, lat, tog, nd);
            check($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d toggles", v), tog, vecs[v].tog);
            check($sformatf("vec%0d done count", v), nd, 1);
        end

        // Full 16-word clip 0 with a start pulse while busy.
        for (int i = 0; i < 64; i++) rom[i] = 16'h0302;
        for (int i = 0; i < 16; i++) rom[i] = 16'h0101;
        run_clip(2'd0, 40, lat, tog, nd);
        check("busy-start done count", nd, 1);
        check("busy-start latency", lat, 16 * 13);

        // Start during FIN is ignored.
        rom[32] = 16'h0000;
        run_clip(2'd2, -2, lat, tog, nd);
        check("fin-start done count", nd, 1);
        check("fin-start idle busy", int'(busy), 0);

        // Stop mid-PLAY, with a concurrent start, then restart one cycle later.
        rom[0] = 16'h0302;
        start = 1'b1; clip_sel = 2'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        stop = 1'b1; start = 1'b1; clip_sel = 2'd3;
        @(posedge clk);
        #1 stop = 1'b0; start = 1'b0;
        @(negedge clk);
        check("stop busy", int'(busy), 0);
        check("stop buzzer", int'(buzzer), 0);
        check("stop done", int'(done), 0);
        model_addr = 6'h00;
        rom[16] = 16'h0302; rom[17] = 16'h0000;
        run_clip(2'd1, -1, lat, tog, nd);
        check("restart after stop done count", nd, 1);

        // Randomised clips.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    w = 16'h0000;
                end else begin
                    case ($urandom_range(0, 3))
                        0:       w[15:8] = 8'd0;
                        1:       w[15:8] = 8'($urandom_range(0, 255));
                        default: w[15:8] = 8'($urandom_range(1, 5));
                    endcase
                    w[7:0] = 8'($urandom_range(0, 3));
                end
                rom[i] = w;
            end
            run_clip(2'($urandom_range(0, 3)), -1, lat, tog, nd);
        end

`ifdef SOUND_PLAYER_LOOP_EN
        // Looping clip: address wraps back to the clip base without a done pulse.
        for (int i = 16; i < 32; i++) rom[i] = 16'h0001;
        loop = 1'b1;
        start = 1'b1; clip_sel = 2'd1;
        @(posedge clk);
        #1 start = 1'b0;
        got_next = 0; seen_done = 0; nxt = 6'h00;
        for (int c = 0; c < 600 && got_next < 2; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (got_next == 0 && rom_addr == 6'h1F) got_next = 1;
            else if (got_next == 1 && rom_addr != 6'h1F) begin
                nxt = rom_addr;
                got_next = 2;
            end
        end
        check("loop wrap seen", got_next, 2);
        check("loop wrap addr", int'(nxt), 16);
        check("loop no done", seen_done, 0);
        check("loop busy", int'(busy), 1);
        loop = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("loop end done count", seen_done, 1);
        check("loop end busy", int'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
